// File: rtl/y86_pkg.sv
// Shared Y86 definitions: program-loader state encoding, loader error codes,
// and the instruction opcodes used by fetch (also handy for building test
// programs).
package y86_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } loader_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

  // Upper nibble of the first instruction byte.
  localparam logic [3:0] OP_HALT   = 4'h0;
  localparam logic [3:0] OP_NOP    = 4'h1;
  localparam logic [3:0] OP_RRMOVQ = 4'h2;
  localparam logic [3:0] OP_IRMOVQ = 4'h3;
  localparam logic [3:0] OP_RMMOVQ = 4'h4;
  localparam logic [3:0] OP_MRMOVQ = 4'h5;
  localparam logic [3:0] OP_OPQ    = 4'h6;
  localparam logic [3:0] OP_JXX    = 4'h7;
  localparam logic [3:0] OP_CALL   = 4'h8;
  localparam logic [3:0] OP_RET    = 4'h9;
  localparam logic [3:0] OP_PUSHQ  = 4'hA;
  localparam logic [3:0] OP_POPQ   = 4'hB;

endpackage

// File: rtl/y86_program_loader_if.sv
// Loader bus: inbound byte stream (valid/ready) and outbound byte-wide
// memory write port.
//   in_valid/in_data : stream source -> loader
//   in_ready         : loader -> stream source
//   mem_we/mem_addr/mem_wdata : loader -> instruction/data memory
// modport slave is the loader; modport master is the stream source / memory.
interface y86_program_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/y86_program_loader.sv
// Y86 program loader: receives a framed byte stream (16-bit little-endian
// length, program bytes, XOR checksum of the program bytes) and writes the
// program into memory starting at LOAD_BASE. Pulses cpu_start once a load
// verifies.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load_start  : arm a new load (honoured in IDLE, DONE, ERROR)
//   bus         : stream in (valid/ready) + memory write port
//   busy        : load in progress
//   done, error : result of last load (held until the next load is armed)
//   err_code    : ERR_NONE / ERR_LEN / ERR_CSUM
//   cpu_start   : one-cycle pulse on entry to DONE
//   byte_count  : program bytes written in the current or last load
//
// state  | meaning
// IDLE   | after reset, waiting for load_start
// LEN_LO | waiting for length low byte
// LEN_HI | waiting for length high byte, range check
// DATA   | writing program bytes
// CHECK  | waiting for checksum byte
// DONE   | load verified
// ERROR  | load rejected (length or checksum)
module y86_program_loader
  import y86_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024,
  parameter int LOAD_BASE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  y86_program_loader_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic                cpu_start,
  output logic [15:0]         byte_count
);

  localparam logic [16:0] LEN_MAX = 17'(MEM_DEPTH - LOAD_BASE);

  loader_state_t state, state_next;
  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [7:0]    checksum;
  logic          xfer;
  logic          arm;
  logic [15:0]   len_rx;
  logic          len_bad;
  logic [15:0]   count_inc;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign arm       = load_start && (state == IDLE || state == DONE || state == ERROR);
  assign len_rx    = {bus.in_data, len_lo};
  assign len_bad   = {1'b0, len_rx} > LEN_MAX;
  assign count_inc = byte_count + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: if (arm) state_next = LEN_LO;
      LEN_LO: if (xfer) state_next = LEN_HI;
      LEN_HI: if (xfer) begin
        if (len_bad)            state_next = ERROR;
        else if (len_rx == '0)  state_next = CHECK;
        else                    state_next = DATA;
      end
      DATA:   if (xfer && count_inc == len) state_next = CHECK;
      CHECK:  if (xfer) state_next = (bus.in_data == checksum) ? DONE : ERROR;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHECK);
    busy         = bus.in_ready;
    done         = (state == DONE);
    error        = (state == ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo        <= '0;
      len           <= '0;
      checksum      <= '0;
      byte_count    <= '0;
      err_code      <= ERR_NONE;
      cpu_start     <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      // High exactly during the first cycle spent in DONE.
      cpu_start  <= (state_next == DONE) && (state != DONE);
      if (arm) begin
        len        <= '0;
        checksum   <= '0;
        byte_count <= '0;
        err_code   <= ERR_NONE;
      end
      if (xfer) begin
        case (state)
          LEN_LO: len_lo <= bus.in_data;
          LEN_HI: begin
            len <= len_rx;
            if (len_bad) err_code <= ERR_LEN;
          end
          DATA: begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ADDR_W'(LOAD_BASE + int'(byte_count));
            bus.mem_wdata <= bus.in_data;
            checksum      <= checksum ^ bus.in_data;
            byte_count    <= count_inc;
          end
          CHECK: if (bus.in_data != checksum) err_code <= ERR_CSUM;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_y86_program_loader.sv
module tb_y86_program_loader;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        busy, done, error, cpu_start;
  logic [1:0]  err_code;
  logic [15:0] byte_count;

  y86_program_loader_if #(.ADDR_W(10)) bus ();

  y86_program_loader #(.ADDR_W(10), .MEM_DEPTH(1024), .LOAD_BASE(0)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .bus(bus),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .cpu_start(cpu_start), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int n_pulses = 0;

  always @(negedge clk) begin
    if (bus.mem_we)  n_writes++;
    if (cpu_start)   n_pulses++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] b [8];
    int         nbytes;
    int         n_prog;
    int         gap;
    bit         mid_start;
    bit         exp_done;
    bit         exp_error;
    int         exp_err;
    int         exp_pulses;
  } vec_t;

  vec_t vecs [5];

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_byte(input logic [7:0] d, input int gap);
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic arm_load(input string name);
    n_writes = 0;
    n_pulses = 0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check({name, "_busy_armed"}, int'(busy), 1);
    check({name, "_done_cleared"}, int'(done), 0);
    check({name, "_byte_count_cleared"}, int'(byte_count), 0);
  endtask

  task automatic run_vec(input vec_t v);
    arm_load(v.name);
    for (int i = 0; i < v.nbytes; i++) begin
      if (v.mid_start && i == 3) begin
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check({v.name, "_mid_start_ignored"}, int'(busy), 1);
      end
      send_byte(v.b[i], v.gap);
      if (i >= 2 && i < 2 + v.n_prog) begin
        check({v.name, "_we"}, int'(bus.mem_we), 1);
        check({v.name, "_addr"}, int'(bus.mem_addr), i - 2);
        check({v.name, "_wdata"}, int'(bus.mem_wdata), int'(v.b[i]));
      end else begin
        check({v.name, "_no_we"}, int'(bus.mem_we), 0);
      end
    end
    repeat (3) @(negedge clk);
    check({v.name, "_done"}, int'(done), int'(v.exp_done));
    check({v.name, "_error"}, int'(error), int'(v.exp_error));
    check({v.name, "_err_code"}, int'(err_code), v.exp_err);
    check({v.name, "_byte_count"}, int'(byte_count), v.n_prog);
    check({v.name, "_writes"}, n_writes, v.n_prog);
    check({v.name, "_cpu_start_pulses"}, n_pulses, v.exp_pulses);
    check({v.name, "_in_ready_idle"}, int'(bus.in_ready), 0);
    check({v.name, "_busy_idle"}, int'(busy), 0);
  endtask

  initial begin
    logic [7:0] nop_b, halt_b;
    nop_b  = {OP_NOP, 4'h0};
    halt_b = {OP_HALT, 4'h0};

    vecs[0] = '{"nominal", '{8'h03, 8'h00, nop_b, nop_b, halt_b, 8'h00, 8'h00, 8'h00},
                6, 3, 0, 1'b0, 1'b1, 1'b0, 0, 1};
    vecs[1] = '{"csum_bad", '{8'h03, 8'h00, nop_b, nop_b, halt_b, 8'hFF, 8'h00, 8'h00},
                6, 3, 0, 1'b0, 1'b0, 1'b1, 2, 0};
    vecs[2] = '{"len_over", '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                2, 0, 0, 1'b0, 1'b0, 1'b1, 1, 0};
    vecs[3] = '{"zero_len", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                3, 0, 0, 1'b0, 1'b1, 1'b0, 0, 1};
    vecs[4] = '{"gapped", '{8'h03, 8'h00, nop_b, nop_b, halt_b, 8'h00, 8'h00, 8'h00},
                6, 3, 1, 1'b1, 1'b1, 1'b0, 0, 1};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_error", int'(error), 0);
    check("reset_err_code", int'(err_code), 0);
    check("reset_cpu_start", int'(cpu_start), 0);
    check("reset_byte_count", int'(byte_count), 0);
    check("reset_in_ready", int'(bus.in_ready), 0);
    check("reset_mem_we", int'(bus.mem_we), 0);
    @(negedge clk);

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Reset in the middle of DATA, then a clean reload.
    arm_load("rst_mid");
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_byte(nop_b, 0);
    check("rst_mid_first_write", int'(bus.mem_we), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_in_ready", int'(bus.in_ready), 0);
    check("rst_mid_mem_we", int'(bus.mem_we), 0);
    check("rst_mid_mem_addr", int'(bus.mem_addr), 0);
    check("rst_mid_mem_wdata", int'(bus.mem_wdata), 0);
    check("rst_mid_byte_count", int'(byte_count), 0);
    check("rst_mid_done", int'(done), 0);
    check("rst_mid_error", int'(error), 0);
    check("rst_mid_err_code", int'(err_code), 0);
    check("rst_mid_cpu_start", int'(cpu_start), 0);
    rst = 1'b0;
    @(negedge clk);
    vecs[0].name = "reload";
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
